rv32i_regfile_mp: RTL and testbench



---
 rtl/rv32i_regfile_pkg.sv | 27 ++
 rtl/rv32i_regfile_rdport.sv | 55 +++++
 rtl/rv32i_regfile_mp.sv | 110 +++++++++++
 tb/tb_rv32i_regfile_mp.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_regfile_pkg.sv
// Shared types and helpers for the rv32i_regfile_mp multi-read-port register file.
// Optional write-first forwarding is enabled by defining RV32I_REGFILE_WR_BYPASS_EN.
package rv32i_regfile_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

    // Address width for a register count (ceil(log2(n))).
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // LSB of field k in a flattened bus of w-bit fields.
    function automatic int unsigned field_lsb(input int unsigned k, input int unsigned w);
        return k * w;
    endfunction

endpackage

// File: rtl/rv32i_regfile_rdport.sv
// One read port: registered address with stall hold, busy/zero masking and,
// when RV32I_REGFILE_WR_BYPASS_EN is defined, a write-first forwarding mux.
module rv32i_regfile_rdport
    import rv32i_regfile_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned AW       = 5,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            busy,
    input  logic [AW-1:0]   rs_addr,
    input  logic [XLEN-1:0] mem_rdata,
`ifdef RV32I_REGFILE_WR_BYPASS_EN
    input  logic            wr,
    input  logic [AW-1:0]   rd_addr,
    input  logic [XLEN-1:0] rd,
`endif
    output logic [AW-1:0]   addr_q,
    output logic [XLEN-1:0] rdata_c
);

    logic [AW-1:0] addr_d;
    logic          is_zero_c;

    always_comb begin
        addr_d = stall ? addr_q : rs_addr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

    assign is_zero_c = (ZERO_REG != 0) && (addr_q == '0);

    // Array read, optional forward of the in-flight write, then masking.
    always_comb begin
        rdata_c = mem_rdata;
`ifdef RV32I_REGFILE_WR_BYPASS_EN
        if (!busy && wr && (rd_addr == addr_q)) begin
            rdata_c = rd;
        end
`endif
        if (busy || is_zero_c) begin
            rdata_c = '0;
        end
    end

endmodule

// File: rtl/rv32i_regfile_mp.sv
// Parametrised multi-read-port integer register file with post-reset clear sequencer.
// Define RV32I_REGFILE_WR_BYPASS_EN for same-cycle write forwarding to the read ports.
module rv32i_regfile_mp
    import rv32i_regfile_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NREGS    = 32,
    parameter int unsigned NRD      = 2,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned AW       = clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rs_addr,
    input  logic                stall,
    input  logic [AW-1:0]       rd_addr,
    input  logic [XLEN-1:0]     rd,
    input  logic                wr,
    output logic [NRD*XLEN-1:0] rs_data,
    output logic                busy
);

    localparam logic [AW-1:0] FIRST_IDX = (ZERO_REG != 0) ? AW'(1) : AW'(0);
    localparam logic [AW-1:0] LAST_IDX  = AW'(NREGS - 1);

    state_e          state_q, state_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic            busy_q, busy_d;
    logic [XLEN-1:0] mem_q [NREGS];

    logic            we_c;
    logic [AW-1:0]   waddr_c;
    logic [XLEN-1:0] wdata_c;

    logic [AW-1:0]   addr_q  [NRD];
    logic [XLEN-1:0] rdata_c [NRD];

    // Clear sequencer owns the write port while busy; external writes are dropped.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        busy_d  = busy_q;
        we_c    = 1'b0;
        waddr_c = rd_addr;
        wdata_c = rd;
        unique case (state_q)
            CLEAR: begin
                we_c    = 1'b1;
                waddr_c = idx_q;
                wdata_c = '0;
                idx_d   = idx_q + AW'(1);
                if (idx_q == LAST_IDX) begin
                    state_d = RUN;
                    busy_d  = 1'b0;
                    idx_d   = FIRST_IDX;
                end
            end
            RUN: begin
                we_c = wr && !((ZERO_REG != 0) && (rd_addr == '0));
            end
        endcase
        if (rst) begin
            we_c = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            idx_q   <= FIRST_IDX;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
        end
    end

    always_ff @(posedge clk) begin
        if (we_c) begin
            mem_q[waddr_c] <= wdata_c;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        rv32i_regfile_rdport #(
            .XLEN     (XLEN),
            .AW       (AW),
            .ZERO_REG (ZERO_REG)
        ) u_rdport (
            .clk       (clk),
            .rst       (rst),
            .stall     (stall),
            .busy      (busy_q),
            .rs_addr   (rs_addr[field_lsb(k, AW) +: AW]),
            .mem_rdata (mem_q[addr_q[k]]),
`ifdef RV32I_REGFILE_WR_BYPASS_EN
            .wr        (wr),
            .rd_addr   (rd_addr),
            .rd        (rd),
`endif
            .addr_q    (addr_q[k]),
            .rdata_c   (rdata_c[k])
        );
        assign rs_data[field_lsb(k, XLEN) +: XLEN] = rdata_c[k];
    end

    assign busy = busy_q;

endmodule

// File: tb/tb_rv32i_regfile_mp.sv
// Directed scoreboard bench for rv32i_regfile_mp (default build and ZERO_REG=0 instance).
module tb_rv32i_regfile_mp;

    localparam int unsigned XLEN = 32;
    localparam int unsigned AW   = 5;
    localparam int unsigned NRD  = 2;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                stall = 1'b0;
    logic                wr = 1'b0;
    logic [NRD*AW-1:0]   rs_addr = '0;
    logic [AW-1:0]       rs_addr_z = '0;
    logic [AW-1:0]       rd_addr = '0;
    logic [XLEN-1:0]     rd = '0;
    logic [NRD*XLEN-1:0] rs_data;
    logic [XLEN-1:0]     rs_data_z;
    logic                busy;
    logic                busy_z;

    int total = 0;
    int bad   = 0;
    int n, nm, nz;

    typedef struct {
        string       tag;
        int unsigned port;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    rv32i_regfile_mp u_dut (
        .clk     (clk),
        .rst     (rst),
        .rs_addr (rs_addr),
        .stall   (stall),
        .rd_addr (rd_addr),
        .rd      (rd),
        .wr      (wr),
        .rs_data (rs_data),
        .busy    (busy)
    );

    rv32i_regfile_mp #(.NRD(1), .ZERO_REG(0)) u_dut_z0 (
        .clk     (clk),
        .rst     (rst),
        .rs_addr (rs_addr_z),
        .stall   (stall),
        .rd_addr (rd_addr),
        .rd      (rd),
        .wr      (wr),
        .rs_data (rs_data_z),
        .busy    (busy_z)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input int unsigned port, input logic [31:0] val);
        exp_t e;
        e.tag  = tag;
        e.port = port;
        e.val  = val;
        sb.push_back(e);
    endtask

    // Port 2 selects the ZERO_REG=0 instance.
    task automatic drain();
        exp_t        e;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = (e.port == 2) ? rs_data_z : rs_data[e.port*XLEN +: XLEN];
            check(e.tag, obs, e.val);
        end
    endtask

    task automatic set_addr(input int unsigned port, input int unsigned a);
        rs_addr[port*AW +: AW] = AW'(a);
    endtask

    task automatic write(input int unsigned a, input logic [31:0] v);
        wr      = 1'b1;
        rd_addr = AW'(a);
        rd      = v;
        tick();
        wr      = 1'b0;
    endtask

    initial begin
        // Clear sequence after reset
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("busy_after_rst", 32'(busy), 32'd1);
        check("busy_z_after_rst", 32'(busy_z), 32'd1);
        push("rd_during_clear", 0, 32'h0);
        drain();
        n = 0; nm = 0; nz = 0;
        while ((busy || busy_z) && n < 100) begin
            tick();
            n++;
            if (!busy && nm == 0) nm = n;
            if (!busy_z && nz == 0) nz = n;
        end
        check("clear_len", 32'(nm), 32'd31);
        check("clear_len_z0", 32'(nz), 32'd32);
        for (int a = 0; a < 32; a++) begin
            set_addr(0, a);
            push("clear_rd", 0, 32'h0);
            tick();
            drain();
        end

        // Write then read, two ports same address
        write(5, 32'hDEADBEEF);
        set_addr(0, 5);
        set_addr(1, 5);
        push("wr_rd_p0", 0, 32'hDEADBEEF);
        push("wr_rd_p1", 1, 32'hDEADBEEF);
        tick();
        drain();

        // Zero register
        write(0, 32'h12345678);
        set_addr(0, 0);
        rs_addr_z = '0;
        push("x0_zero", 0, 32'h0);
        push("x0_plain", 2, 32'h12345678);
        tick();
        drain();

        // Stall hold
        write(9, 32'h99);
        write(7, 32'h11);
        set_addr(0, 7);
        push("stall_pre", 0, 32'h11);
        tick();
        drain();
        stall   = 1'b1;
        set_addr(0, 9);
        wr      = 1'b1;
        rd_addr = AW'(7);
        rd      = 32'h22;
        push("stall_wr_seen", 0, 32'h22);
        tick();
        wr = 1'b0;
        drain();
        push("stall_hold", 0, 32'h22);
        tick();
        drain();
        stall = 1'b0;
        push("stall_release", 0, 32'h99);
        tick();
        drain();

        // Write forwarding (or not) to a latched address
        write(3, 32'h33);
        set_addr(0, 3);
        push("byp_pre", 0, 32'h33);
        tick();
        drain();
        wr      = 1'b1;
        rd_addr = AW'(3);
        rd      = 32'hCAFE;
        #1;
`ifdef RV32I_REGFILE_WR_BYPASS_EN
        push("byp_same", 0, 32'hCAFE);
`else
        push("byp_same", 0, 32'h33);
`endif
        push("byp_other", 1, 32'hDEADBEEF);
        drain();
        tick();
        wr = 1'b0;
        push("byp_next", 0, 32'hCAFE);
        drain();

        // Reset mid-clear, dropped write while busy
        write(20, 32'hAA);
        set_addr(0, 20);
        set_addr(1, 2);
        push("x20_pre", 0, 32'hAA);
        tick();
        drain();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (9) tick();
        check("busy_mid_clear", 32'(busy), 32'd1);
        push("busy_mask", 0, 32'h0);
        drain();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            if (n == 15) begin
                wr      = 1'b1;
                rd_addr = AW'(2);
                rd      = 32'h77;
            end
            tick();
            wr = 1'b0;
            n++;
        end
        check("reclear_len", 32'(n), 32'd31);
        push("x20_cleared", 0, 32'h0);
        push("dropped_wr", 1, 32'h0);
        tick();
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
